encoder_round_ctrl: RTL

Round sequencer for the encoder datapath. Accepts one top-level start and drives the five transform stages in fixed order: column parity, rotate, permute, revaluate, add-RC. It uses each stage's start/ready handshake and repeats this sequence for a parameterised number of rounds. It sits between the top-level command interface and `DataPath`, owns all `start_*` strobes, and reports completion, progress and watchdog errors.

---
 rtl/encoder_pkg.sv | 43 ++++
 rtl/encoder_round_ctrl_if.sv | 33 +++
 rtl/stage_watchdog.sv | 33 +++
 rtl/encoder_round_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder round sequencer.
// Holds the sequencer state encoding, the stage codes reported on the
// `stage` output, default round/timeout values and small state helpers.
package encoder_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PAR_GO, S_PAR_WAIT,
        S_ROT_GO, S_ROT_WAIT,
        S_PER_GO, S_PER_WAIT,
        S_REV_GO, S_REV_WAIT,
        S_RC_GO,  S_RC_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] STG_PAR  = 3'd0;
    localparam logic [2:0] STG_ROT  = 3'd1;
    localparam logic [2:0] STG_PER  = 3'd2;
    localparam logic [2:0] STG_REV  = 3'd3;
    localparam logic [2:0] STG_RC   = 3'd4;
    localparam logic [2:0] STG_IDLE = 3'd7;

    localparam int NUM_ROUNDS_DEF = 24;
    localparam int TIMEOUT_DEF    = 1023;

    // Stage code reported for a given state; IDLE and DONE both report 7.
    function automatic logic [2:0] stage_of(input state_t s);
        case (s)
            S_PAR_GO, S_PAR_WAIT: stage_of = STG_PAR;
            S_ROT_GO, S_ROT_WAIT: stage_of = STG_ROT;
            S_PER_GO, S_PER_WAIT: stage_of = STG_PER;
            S_REV_GO, S_REV_WAIT: stage_of = STG_REV;
            S_RC_GO,  S_RC_WAIT:  stage_of = STG_RC;
            default:              stage_of = STG_IDLE;
        endcase
    endfunction

    function automatic logic is_wait(input state_t s);
        is_wait = (s == S_PAR_WAIT) || (s == S_ROT_WAIT) || (s == S_PER_WAIT) ||
                  (s == S_REV_WAIT) || (s == S_RC_WAIT);
    endfunction

endpackage

// File: rtl/encoder_round_ctrl_if.sv
// Command and stage handshake bundle of the encoder round sequencer.
//   start, abort            : top-level command inputs
//   ready_*                 : stage-complete indications from the datapath
//   start_*                 : one-cycle stage start pulses to the datapath
//   busy, done, error       : status
//   round, stage            : progress (round index, active stage code)
// slave  : the sequencer side
// master : the command issuer / datapath side
interface encoder_round_ctrl_if;
    logic       start;
    logic       abort;
    logic       ready_par, ready_rot, ready_per, ready_rev, ready_RC;
    logic       start_par, start_rot, start_per, start_rev, start_RC;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] round;
    logic [2:0] stage;

    modport slave (
        input  start, abort,
        input  ready_par, ready_rot, ready_per, ready_rev, ready_RC,
        output start_par, start_rot, start_per, start_rev, start_RC,
        output busy, done, error, round, stage
    );

    modport master (
        output start, abort,
        output ready_par, ready_rot, ready_per, ready_rev, ready_RC,
        input  start_par, start_rot, start_per, start_rev, start_RC,
        input  busy, done, error, round, stage
    );
endinterface

// File: rtl/stage_watchdog.sv
// Wait-cycle watchdog shared by all WAIT states of the sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear the count (held while not waiting)
//   en       : count one more cycle spent waiting
//   timeout  : this is the TIMEOUT-th waiting cycle; never set when TIMEOUT=0
module stage_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (en)
            cnt_q <= cnt_q + 1'b1;
    end

    // The count equals the number of waiting cycles already completed, so the
    // flag fires in the last allowed waiting cycle and the FSM leaves after
    // exactly TIMEOUT cycles in WAIT.
    assign timeout = (TIMEOUT != 0) && en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/encoder_round_ctrl.sv
// Round sequencer for the encoder datapath.
// Drives the five transform stages (par, rot, per, rev, RC) in order through
// their start/ready handshakes, repeating for NUM_ROUNDS rounds (1..31).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : encoder_round_ctrl_if.slave (command, handshakes, status)
// Every output is a register loaded from the next-state value, so outputs
// line up with the state they describe without any input-to-output path.
module encoder_round_ctrl
    import encoder_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    encoder_round_ctrl_if.slave  bus
);
    state_t     state_q, state_n;
    logic [4:0] round_q, round_n;
    logic       error_q, error_n;
    logic [4:0] start_q;
    logic       busy_q, done_q;
    logic [2:0] stage_q;
    logic       in_wait, timeout;

    assign in_wait = is_wait(state_q);

    stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .en      (in_wait),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            error_q <= 1'b0;
            start_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stage_q <= STG_IDLE;
        end else begin
            state_q <= state_n;
            round_q <= round_n;
            error_q <= error_n;
            start_q <= {state_n == S_RC_GO,  state_n == S_REV_GO, state_n == S_PER_GO,
                        state_n == S_ROT_GO, state_n == S_PAR_GO};
            busy_q  <= (state_n != S_IDLE);
            done_q  <= (state_n == S_DONE);
            stage_q <= stage_of(state_n);
        end
    end

    always_comb begin
        state_n = state_q;
        round_n = round_q;
        error_n = error_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n = S_PAR_GO;
                    round_n = '0;
                    error_n = 1'b0;
                end
            end
            S_PAR_GO: state_n = S_PAR_WAIT;
            S_ROT_GO: state_n = S_ROT_WAIT;
            S_PER_GO: state_n = S_PER_WAIT;
            S_REV_GO: state_n = S_REV_WAIT;
            S_RC_GO:  state_n = S_RC_WAIT;
            S_PAR_WAIT: begin
                if (bus.ready_par) state_n = S_ROT_GO;
                else if (timeout) begin state_n = S_IDLE; error_n = 1'b1; end
            end
            S_ROT_WAIT: begin
                if (bus.ready_rot) state_n = S_PER_GO;
                else if (timeout) begin state_n = S_IDLE; error_n = 1'b1; end
            end
            S_PER_WAIT: begin
                if (bus.ready_per) state_n = S_REV_GO;
                else if (timeout) begin state_n = S_IDLE; error_n = 1'b1; end
            end
            S_REV_WAIT: begin
                if (bus.ready_rev) state_n = S_RC_GO;
                else if (timeout) begin state_n = S_IDLE; error_n = 1'b1; end
            end
            S_RC_WAIT: begin
                if (bus.ready_RC) begin
                    if (round_q == 5'(NUM_ROUNDS - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_PAR_GO;
                        round_n = round_q + 5'd1;
                    end
                end else if (timeout) begin
                    state_n = S_IDLE;
                    error_n = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Abort overrides readiness and the watchdog; round and error are kept.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_n = S_IDLE;
            round_n = round_q;
            error_n = error_q;
        end
    end

    assign bus.start_par = start_q[0];
    assign bus.start_rot = start_q[1];
    assign bus.start_per = start_q[2];
    assign bus.start_rev = start_q[3];
    assign bus.start_RC  = start_q[4];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.round     = round_q;
    assign bus.stage     = stage_q;

endmodule
